dmem_responder: RTL and testbench

- Memory-side responder for the per-channel valid/ready read/write protocol that data-cache and memory-controller channels drive toward memory.
- Holds a 2^ADDR_BITS x DATA_BITS data array.
- Each channel's request is accepted, a fixed latency is counted down, and one array access per cycle is granted by round-robin arbitration.
- Ready is held until the initiator drops valid. Acts as the data memory model behind the cache/controller in simulation and on FPGA.

---
 rtl/dmem_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// This is a memory-side responder for per-channel valid/ready read and write
// channels. Each channel runs its own small FSM:
//   1. accept a request and latch its address (and data for a write),
//   2. count down a fixed latency,
//   3. wait for an array grant.
// One array access is granted per cycle, in round-robin order across the
// eligible channels. After the grant, the ready output is held until the
// initiator drops valid. A backdoor preload port can write the array
// directly. In a cycle where a preload happens, no channel is granted.
//
// Ports:
//   clk                clock; all logic runs on posedge
//   reset              synchronous reset, active low
//   mem_read_valid     per-channel read request
//   mem_read_address   per-channel read address
//   mem_read_ready     per-channel read acknowledge (read data is valid)
//   mem_read_data      per-channel read return data (held after the handshake)
//   mem_write_valid    per-channel write request
//   mem_write_address  per-channel write address
//   mem_write_data     per-channel write data
//   mem_write_ready    per-channel write acknowledge
//   load_valid         preload strobe; blocks channel grants for that cycle
//   load_address       preload address
//   load_data          preload data
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_valid,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int PTR_W = (NUM_CHANNELS < 2) ? 1 : $clog2(NUM_CHANNELS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_R,
    WAIT_W,
    RESP_R,
    RESP_W
  } state_e;

  // Per-channel request state
  state_e                                 state_q [NUM_CHANNELS];
  logic   [CNT_W-1:0]                     cnt_q   [NUM_CHANNELS];
  logic   [ADDR_BITS-1:0]                 addr_q  [NUM_CHANNELS];
  logic   [DATA_BITS-1:0]                 wdata_q [NUM_CHANNELS];
  logic   [NUM_CHANNELS-1:0]              read_ready_q;
  logic   [NUM_CHANNELS-1:0]              write_ready_q;
  logic   [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q;

  // Arbitration state
  logic   [PTR_W-1:0]                     ptr_q;
  logic   [PTR_W-1:0]                     ptr_d;

  // Data array
  logic   [DATA_BITS-1:0]                 mem_q [DEPTH];

  logic   [NUM_CHANNELS-1:0]              eligible;
  logic   [NUM_CHANNELS-1:0]              grant_oh;
  logic                                   grant_any;
  logic                                   grant_en;
  logic   [PTR_W-1:0]                     grant_idx;

  logic                                   mem_we;
  logic   [ADDR_BITS-1:0]                 mem_waddr;
  logic   [DATA_BITS-1:0]                 mem_wdata;

  assign mem_read_ready  = read_ready_q;
  assign mem_write_ready = write_ready_q;
  assign mem_read_data   = read_data_q;

  // Returns the channel index that sits 'offset' positions after 'base',
  // wrapping modulo NUM_CHANNELS. This also works when NUM_CHANNELS is
  // not a power of two.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
    return PTR_W'(sum);
  endfunction

  // A channel is eligible once its countdown has expired while it waits.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default before any
    // conditional logic. Without the default, a path that skips the
    // assignment would infer a latch.
    eligible = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      eligible[c] = ((state_q[c] == WAIT_R) || (state_q[c] == WAIT_W)) &&
                    (cnt_q[c] == '0);
    end
  end

  // Round-robin search. The search starts at the pointer, and the first
  // eligible channel wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!grant_any && eligible[rr_index(ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_index(ptr_q, k);
      end
    end
  end

  // A preload owns the array port for its cycle. Waiting channels are
  // held back, and the pointer stays where it is.
  assign grant_en = grant_any && !load_valid;

  always_comb begin
    grant_oh = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_oh[c] = grant_en && (grant_idx == PTR_W'(c));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Single array write port, shared by the preload and a granted write.
  // The two never occur in the same cycle, because a preload blocks grants.
  always_comb begin
    mem_we    = load_valid;
    mem_waddr = load_address;
    mem_wdata = load_data;
    if (grant_en && (state_q[grant_idx] == WAIT_W)) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q[grant_idx];
      mem_wdata = wdata_q[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the whole array is cleared on reset so that read data can never
    // be unknown. This makes the array a register file, not a RAM macro.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Per-channel FSMs and their registered ready/data outputs, plus the
  // arbitration pointer.
  always_ff @(posedge clk) begin
    // NOTE: all state here is updated with non-blocking assignments.
    // Every channel then sees the values from before this edge, and the
    // result does not depend on statement order.
    if (!reset) begin
      ptr_q         <= '0;
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state_q[c])
          IDLE: begin
            // If read and write are both requested, the read is taken first.
            // The write is sampled again after the read handshake completes.
            if (mem_read_valid[c]) begin
              addr_q[c]  <= mem_read_address[c];
              cnt_q[c]   <= CNT_INIT;
              state_q[c] <= WAIT_R;
            end else if (mem_write_valid[c]) begin
              addr_q[c]  <= mem_write_address[c];
              wdata_q[c] <= mem_write_data[c];
              cnt_q[c]   <= CNT_INIT;
              state_q[c] <= WAIT_W;
            end
          end

          WAIT_R: begin
            if (cnt_q[c] != '0) begin
              cnt_q[c] <= cnt_q[c] - CNT_W'(1);
            end else if (grant_oh[c]) begin
              read_data_q[c]  <= mem_q[addr_q[c]];
              read_ready_q[c] <= 1'b1;
              state_q[c]      <= RESP_R;
            end
          end

          WAIT_W: begin
            if (cnt_q[c] != '0) begin
              cnt_q[c] <= cnt_q[c] - CNT_W'(1);
            end else if (grant_oh[c]) begin
              // The array itself is written through the shared write port.
              write_ready_q[c] <= 1'b1;
              state_q[c]       <= RESP_W;
            end
          end

          RESP_R: begin
            // Read data stays on the bus after ready drops.
            if (!mem_read_valid[c]) begin
              read_ready_q[c] <= 1'b0;
              state_q[c]      <= IDLE;
            end
          end

          RESP_W: begin
            if (!mem_write_valid[c]) begin
              write_ready_q[c] <= 1'b0;
              state_q[c]       <= IDLE;
            end
          end

          default: state_q[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// This is a directed bench for dmem_responder with the default parameters
// (ADDR_BITS=8, DATA_BITS=8, NUM_CHANNELS=4, LATENCY=2).
//
// Single-channel transactions come from a table of records:
//   - Each record gives the channel, direction, address, write data and
//     expected read data.
//   - Each record is applied through one handshake task. That task checks:
//     latency, data, ready hold, and ready release.
//
// Hand-written sequences cover the multi-cycle corner cases:
//   - round-robin ordering,
//   - simultaneous read and write on one channel,
//   - preload stalls,
//   - reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;
  localparam int UNCONTENDED_CYCLES = LAT + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NC-1:0]          rv;
  logic [NC-1:0][AB-1:0]  ra;
  logic [NC-1:0]          rr;
  logic [NC-1:0][DB-1:0]  rd;
  logic [NC-1:0]          wv;
  logic [NC-1:0][AB-1:0]  wa;
  logic [NC-1:0][DB-1:0]  wd;
  logic [NC-1:0]          wr_rdy;
  logic                   load_valid;
  logic [AB-1:0]          load_address;
  logic [DB-1:0]          load_data;

  int total = 0;
  int bad   = 0;

  dmem_responder #(
    .ADDR_BITS   (AB),
    .DATA_BITS   (DB),
    .NUM_CHANNELS(NC),
    .LATENCY     (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (rv),
    .mem_read_address (ra),
    .mem_read_ready   (rr),
    .mem_read_data    (rd),
    .mem_write_valid  (wv),
    .mem_write_address(wa),
    .mem_write_data   (wd),
    .mem_write_ready  (wr_rdy),
    .load_valid       (load_valid),
    .load_address     (load_address),
    .load_data        (load_data)
  );

  typedef struct {
    int          ch;
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Advance to just after the next active edge. Outputs are sampled here,
  // and inputs driven here are seen at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_valid   = 1'b1;
    load_address = a;
    load_data    = d;
    tick();
    load_valid   = 1'b0;
  endtask

  // Run one uncontended handshake on one channel.
  task automatic txn(input int ch, input bit wr, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp, input string nm);
    int  n;
    bit  got;
    if (wr) begin
      wv[ch] = 1'b1; wa[ch] = addr; wd[ch] = wdata;
    end else begin
      rv[ch] = 1'b1; ra[ch] = addr;
    end
    tick();
    // Change the inputs after acceptance. The latched request must ignore them.
    ra[ch] = ~addr; wa[ch] = ~addr; wd[ch] = ~wdata;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = wr ? wr_rdy[ch] : rr[ch];
    end
    check({nm, " latency"}, 32'(n), 32'(UNCONTENDED_CYCLES));
    if (!wr) check({nm, " data"}, 32'(rd[ch]), 32'(exp));
    tick();
    check({nm, " ready held"}, 32'(wr ? wr_rdy[ch] : rr[ch]), 32'd1);
    if (wr) wv[ch] = 1'b0; else rv[ch] = 1'b0;
    tick();
    check({nm, " ready released"}, 32'(wr ? wr_rdy[ch] : rr[ch]), 32'd0);
    if (!wr) check({nm, " data kept"}, 32'(rd[ch]), 32'(exp));
  endtask

  // All four channels read addresses 1..4 in the same cycle. Grants must
  // start at 'first' and rotate, one per cycle.
  task automatic run_round(input int first, input string nm);
    int rise [NC];
    for (int c = 0; c < NC; c++) begin
      rv[c]   = 1'b1;
      ra[c]   = AB'(c + 1);
      rise[c] = 0;
    end
    tick();
    for (int n = 1; n <= 12; n++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (rr[c] && rise[c] == 0) rise[c] = n;
      end
    end
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s ch%0d rise", nm, c), 32'(rise[c]),
            32'(UNCONTENDED_CYCLES + ((c - first + NC) % NC)));
      check($sformatf("%s ch%0d data", nm, c), 32'(rd[c]), 32'(17 * (c + 1)));
    end
    rv = '0;
    tick();
    check({nm, " all released"}, 32'(rr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit got;

    tbl[0] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, "ch0 rd 10"};
    tbl[1] = '{2, 1'b0, 8'h20, 8'h00, 8'h00, "ch2 rd 20 before wr"};
    tbl[2] = '{1, 1'b1, 8'h20, 8'h3C, 8'h00, "ch1 wr 20"};
    tbl[3] = '{2, 1'b0, 8'h20, 8'h00, 8'h3C, "ch2 rd 20 after wr"};
    tbl[4] = '{1, 1'b0, 8'h00, 8'h00, 8'h00, "ch1 rd 00"};
    tbl[5] = '{3, 1'b1, 8'hFF, 8'h5A, 8'h00, "ch3 wr FF"};
    tbl[6] = '{0, 1'b1, 8'h00, 8'hE1, 8'h00, "ch0 wr 00"};
    tbl[7] = '{2, 1'b0, 8'h00, 8'h00, 8'hE1, "ch2 rd 00"};
    tbl[8] = '{3, 1'b0, 8'hFF, 8'h00, 8'h5A, "ch3 rd FF"};

    reset = 1'b0;
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
    load_valid = 1'b0; load_address = '0; load_data = '0;
    tick();
    tick();
    check("reset read ready", 32'(rr), 32'd0);
    check("reset write ready", 32'(wr_rdy), 32'd0);
    check("reset read data", 32'(rd), 32'd0);
    reset = 1'b1;
    tick();

    preload(8'h10, 8'hA5);
    for (int i = 1; i <= 4; i++) preload(AB'(i), DB'(17 * i));
    preload(8'h05, 8'h5E);

    // Table of uncontended transactions. The last one is granted to ch3,
    // which leaves the pointer at 0.
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].name);
      tick();
    end

    // Round-robin from pointer 0, repeated, then from pointer 2.
    run_round(0, "rr ptr0 a");
    run_round(0, "rr ptr0 b");
    txn(1, 1'b0, 8'h02, 8'h00, 8'h22, "ch1 rd 02 sets ptr2");
    run_round(2, "rr ptr2");

    // Read and write both requested on ch0, to the same address.
    rv[0] = 1'b1; ra[0] = 8'h05;
    wv[0] = 1'b1; wa[0] = 8'h05; wd[0] = 8'h77;
    tick();
    n = 0; got = 1'b0;
    while (!got && n < 20) begin tick(); n++; got = rr[0]; end
    check("rw read latency", 32'(n), 32'(UNCONTENDED_CYCLES));
    check("rw read old value", 32'(rd[0]), 32'h5E);
    check("rw write not yet acked", 32'(wr_rdy[0]), 32'd0);
    rv[0] = 1'b0;
    tick();
    check("rw read released", 32'(rr[0]), 32'd0);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin tick(); n++; got = wr_rdy[0]; end
    check("rw write latency after read", 32'(n), 32'(UNCONTENDED_CYCLES + 1));
    wv[0] = 1'b0;
    tick();
    check("rw write released", 32'(wr_rdy[0]), 32'd0);
    txn(0, 1'b0, 8'h05, 8'h00, 8'h77, "ch0 rd 05 after rw");

    // A preload held for two cycles while ch1 is eligible delays its grant by two.
    rv[1] = 1'b1; ra[1] = 8'h40;
    tick();
    tick();
    tick();
    load_valid = 1'b1; load_address = 8'h40; load_data = 8'hC3;
    tick();
    check("load stall cycle 1", 32'(rr[1]), 32'd0);
    load_address = 8'h41; load_data = 8'hD4;
    tick();
    check("load stall cycle 2", 32'(rr[1]), 32'd0);
    load_valid = 1'b0;
    tick();
    check("load stall grant", 32'(rr[1]), 32'd1);
    check("load stall data", 32'(rd[1]), 32'hC3);
    rv[1] = 1'b0;
    tick();
    check("load stall released", 32'(rr[1]), 32'd0);
    txn(2, 1'b0, 8'h41, 8'h00, 8'hD4, "ch2 rd 41 preloaded");

    // Reset while ch3 is still counting down a write to 0x30.
    wv[3] = 1'b1; wa[3] = 8'h30; wd[3] = 8'h99;
    tick();
    tick();
    reset = 1'b0;
    wv[3] = 1'b0;
    tick();
    check("mid reset read ready", 32'(rr), 32'd0);
    check("mid reset write ready", 32'(wr_rdy), 32'd0);
    check("mid reset read data", 32'(rd), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("no late write ack", 32'(wr_rdy), 32'd0);
    txn(0, 1'b0, 8'h30, 8'h00, 8'h00, "ch0 rd 30 after reset");
    txn(3, 1'b0, 8'h10, 8'h00, 8'h00, "ch3 rd 10 cleared by reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
